// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding and iteration-counter width for the add/shift multiplier controller
package mult_pkg;
  typedef enum logic [2:0] {IDLE, CLR, ADD, SHIFT, HOLD} state_t;
  localparam int N_BITS_DEF = 8;
  localparam int ITER_W = $clog2(N_BITS_DEF);
endpackage

// File: rtl/mult_control.sv
// mult_control: sequencer for a signed add/shift multiplier datapath (X:A:B)
module mult_control
  import mult_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Clr_Ld,
  output logic Clear_AX,
  output logic Add_En,
  output logic Sub_En,
  output logic Shift_En,
  output logic Done
);
  localparam int IW = $clog2(N_BITS);
  localparam logic [IW-1:0] LAST = IW'(N_BITS - 1);
  state_t state, state_n;
  logic [IW-1:0] iter, iter_n;
  logic last;
  assign last = iter == LAST;
  // state and iteration counter register; reset wins over everything
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      iter  <= '0;
    end else begin
      state <= state_n;
      iter  <= iter_n;
    end
  end
  // next-state and strobe decode; the final iteration subtracts (sign bit of the multiplier)
  always_comb begin
    state_n  = state;
    iter_n   = iter;
    Clr_Ld   = 1'b0;
    Clear_AX = 1'b0;
    Add_En   = 1'b0;
    Sub_En   = 1'b0;
    Shift_En = 1'b0;
    Done     = 1'b0;
    unique case (state)
      IDLE: begin
        Clr_Ld  = ClearA_LoadB & ~Run;
        state_n = Run ? CLR : IDLE;
        iter_n  = Run ? '0 : iter;
      end
      CLR: begin
        Clear_AX = 1'b1;
        state_n  = ADD;
      end
      ADD: begin
        Add_En  = M & ~last;
        Sub_En  = M & last;
        state_n = SHIFT;
      end
      SHIFT: begin
        Shift_En = 1'b1;
        state_n  = last ? HOLD : ADD;
        iter_n   = last ? iter : iter + IW'(1);
      end
      HOLD: begin
        Done    = 1'b1;
        state_n = Run ? HOLD : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
